// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_UNKNOWN
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    // flags = {N, Z, C, V}
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v, ge;
        n  = flags[3];
        z  = flags[2];
        c  = flags[1];
        v  = flags[0];
        ge = (n == v);
        case (cond)
            4'b0000: cond_holds = z;
            4'b0001: cond_holds = ~z;
            4'b0010: cond_holds = c;
            4'b0011: cond_holds = ~c;
            4'b0100: cond_holds = n;
            4'b0101: cond_holds = ~n;
            4'b0110: cond_holds = v;
            4'b0111: cond_holds = ~v;
            4'b1000: cond_holds = c & ~z;
            4'b1001: cond_holds = ~(c & ~z);
            4'b1010: cond_holds = ge;
            4'b1011: cond_holds = ~ge;
            4'b1100: cond_holds = ~z & ge;
            4'b1101: cond_holds = ~(~z & ge);
            4'b1110: cond_holds = 1'b1;
            default: cond_holds = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/arm_mc_condlogic.sv
// Condition evaluation, NZCV flag register and the per-instruction CondExR latch.
module arm_mc_condlogic
    import arm_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       cond_latch,
    output logic       cond_ex_r
);

    logic [3:0] flags;

    // Flag writes are qualified by the decision latched in DECODE, not a live re-evaluation.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= '0;
            cond_ex_r <= 1'b0;
        end else begin
            if (cond_latch)
                cond_ex_r <= cond_holds(cond, flags);
            if (flag_w[1] && cond_ex_r)
                flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex_r)
                flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: sequencing FSM, ALU decoder and write-strobe gating.
module arm_mc_controller
    import arm_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc
);

    state_t     state;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cond;
    logic       unused_instr_bits;

    // Instr carries bits [31:12]; Rn/Rd are not needed by the controller.
    assign cond              = Instr[19:16];
    assign op                = Instr[15:14];
    assign funct             = Instr[13:8];
    assign unused_instr_bits = ^Instr[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_MEM:  state <= S_MEMADR;
                        OP_DP:   state <= funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_BR:   state <= S_BRANCH;
                        default: state <= S_UNKNOWN;
                    endcase
                end
                S_MEMADR:   state <= funct[0] ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state <= S_MEMWB;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_UNKNOWN:  state <= S_UNKNOWN;
                default:    state <= S_FETCH;
            endcase
        end
    end

    logic next_pc, ir_w, reg_w, mem_w, branch, alu_op;

    always_comb begin
        next_pc   = 1'b0;
        ir_w      = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_WD;
        ResultSrc = RES_ALUOUT;
        case (state)
            S_FETCH: begin
                next_pc   = 1'b1;
                ir_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    logic       arith, is_cmp, no_write;
    logic [1:0] flag_w;

    always_comb begin
        ALUControl = ALU_ADD;
        arith      = 1'b0;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: begin ALUControl = ALU_ADD; arith = 1'b1; end
                4'b0010: begin ALUControl = ALU_SUB; arith = 1'b1; end
                4'b0000: ALUControl = ALU_AND;
                4'b1100: ALUControl = ALU_ORR;
                4'b1010: begin ALUControl = ALU_SUB; arith = 1'b1; end
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

    // Instr is stable after FETCH, so re-decoding CMP in ALUWB keeps NoWrite held there.
    assign is_cmp   = (funct[4:1] == 4'b1010);
    assign no_write = is_cmp & (alu_op | (state == S_ALUWB));
    assign flag_w   = alu_op ? {funct[0], funct[0] & arith} : 2'b00;

    logic cond_ex_r;

    arm_mc_condlogic u_condlogic (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .alu_flags  (ALUFlags),
        .flag_w     (flag_w),
        .cond_latch (state == S_DECODE),
        .cond_ex_r  (cond_ex_r)
    );

    assign PCWrite  = ~reset & (next_pc | (branch & cond_ex_r));
    assign RegWrite = ~reset & reg_w & cond_ex_r & ~no_write;
    assign MemWrite = ~reset & mem_w & cond_ex_r;
    assign IRWrite  = ~reset & ir_w;
    assign RegSrc   = {op == OP_MEM, op == OP_BR};
    assign ImmSrc   = op;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: per-instruction expected output trace vs. per-cycle monitor.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;

  always #5 clk = ~clk;

  arm_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc)
  );

  // Output vector: {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ImmSrc,ALUSrcA,ALUSrcB,ALUControl,ResultSrc}
  typedef struct packed {
    logic [15:0] exp;
    logic [15:0] mask;
    logic [3:0]  id;
  } rec_t;

  rec_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [3:0]  mflags = '0;
  logic [31:0] cur_ins = '0;

  function automatic string step_name(input logic [3:0] id);
    case (id)
      4'd0:    return "fetch";
      4'd1:    return "decode";
      4'd2:    return "memadr";
      4'd3:    return "memread";
      4'd4:    return "memwb";
      4'd5:    return "memwrite";
      4'd6:    return "execute";
      4'd7:    return "aluwb";
      4'd8:    return "branch";
      4'd9:    return "unknown";
      default: return "reset_strobes";
    endcase
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] vec(input bit pcw, input bit memw, input bit regw, input bit irw,
                                      input bit adr, input logic [1:0] op, input bit srca,
                                      input logic [1:0] srcb, input logic [1:0] alu, input logic [1:0] res);
    logic [1:0] rs;
    rs = {op == 2'b01, op == 2'b10};
    return {pcw, memw, regw, irw, adr, rs, op, srca, srcb, alu, res};
  endfunction

  function automatic rec_t mkrec(input logic [15:0] e, input logic [15:0] m, input logic [3:0] id);
    rec_t r;
    r.exp = e; r.mask = m; r.id = id;
    return r;
  endfunction

  always @(negedge clk) begin
    rec_t        r;
    logic [15:0] act;
    if (sb.size() != 0) begin
      r   = sb.pop_front();
      act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
             ALUSrcA, ALUSrcB, ALUControl, ResultSrc};
      checks++;
      if ((act & r.mask) === (r.exp & r.mask))
        passes++;
      else
        $display("FAIL %s instr=%h: got %h required %h (mask %h)",
                 step_name(r.id), cur_ins, act, r.exp, r.mask);
    end
  end

  // Builds the expected per-cycle trace for one instruction, then drives it.
  // cut >= 0 asserts reset during that cycle of the instruction.
  task automatic run_instr(input logic [31:0] ins, input int cut_in, input logic [4:0] afv);
    logic [3:0] af [8];
    rec_t       recs[$];
    int         cut;
    logic [3:0] c;
    logic [1:0] op, alu;
    logic [5:0] f;
    bit         p, arith, cmp;
    cut = cut_in;
    for (int unsigned i = 0; i < 8; i++)
      af[i] = afv[4] ? afv[3:0] : 4'($urandom_range(0, 15));
    c  = ins[31:28];
    op = ins[27:26];
    f  = ins[25:20];
    p  = cond_ok(c, mflags);
    recs.push_back(mkrec(vec(1, 0, 0, 1, 0, op, 1, 2'b10, 2'b00, 2'b10), 16'hFFFF, 4'd0));
    recs.push_back(mkrec(vec(0, 0, 0, 0, 0, op, 1, 2'b10, 2'b00, 2'b10), 16'hFFFF, 4'd1));
    case (op)
      2'b01: begin
        recs.push_back(mkrec(vec(0, 0, 0, 0, 0, op, 0, 2'b01, 2'b00, 2'b00), 16'hFFFF, 4'd2));
        if (f[0]) begin
          recs.push_back(mkrec(vec(0, 0, 0, 0, 1, op, 0, 2'b00, 2'b00, 2'b00), 16'hFFFF, 4'd3));
          recs.push_back(mkrec(vec(0, 0, p, 0, 0, op, 0, 2'b00, 2'b00, 2'b01), 16'hFFFF, 4'd4));
        end else begin
          recs.push_back(mkrec(vec(0, p, 0, 0, 1, op, 0, 2'b00, 2'b00, 2'b00), 16'hFFFF, 4'd5));
        end
      end
      2'b00: begin
        arith = 0; cmp = 0;
        case (f[4:1])
          4'b0100: begin alu = 2'b00; arith = 1; end
          4'b0010: begin alu = 2'b01; arith = 1; end
          4'b0000: alu = 2'b10;
          4'b1100: alu = 2'b11;
          4'b1010: begin alu = 2'b01; arith = 1; cmp = 1; end
          default: alu = 2'b00;
        endcase
        recs.push_back(mkrec(vec(0, 0, 0, 0, 0, op, 0, f[5] ? 2'b01 : 2'b00, alu, 2'b00), 16'hFFFF, 4'd6));
        recs.push_back(mkrec(vec(0, 0, p && !cmp, 0, 0, op, 0, 2'b00, 2'b00, 2'b00), 16'hFFFF, 4'd7));
        if (p && f[0]) begin
          mflags[3:2] = af[2][3:2];
          if (arith) mflags[1:0] = af[2][1:0];
        end
      end
      2'b10: begin
        recs.push_back(mkrec(vec(p, 0, 0, 0, 0, op, 0, 2'b01, 2'b00, 2'b10), 16'hFFFF, 4'd8));
      end
      default: begin
        for (int unsigned i = 0; i < 5; i++)
          recs.push_back(mkrec(vec(0, 0, 0, 0, 0, op, 0, 2'b00, 2'b00, 2'b00), 16'hFFFF, 4'd9));
        if (cut < 0) cut = 6;
      end
    endcase
    if (cut >= 0 && cut < recs.size()) begin
      while (recs.size() > cut) void'(recs.pop_back());
      recs.push_back(mkrec(16'h0000, 16'hF000, 4'd10));
      mflags = '0;
    end else begin
      cut = -1;
    end
    cur_ins = ins;
    Instr   = ins[31:12];
    foreach (recs[i]) sb.push_back(recs[i]);
    for (int i = 0; i < recs.size(); i++) begin
      ALUFlags = af[i];
      reset    = (i == cut);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [3:0] cmds [5];
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] f;
    int         r;
    cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    cond = 4'($urandom_range(0, 15));
    r    = $urandom_range(0, 15);
    op   = (r < 6) ? 2'b00 : (r < 11) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
    f    = 6'($urandom_range(0, 63));
    if (op == 2'b00 && $urandom_range(0, 5) != 5)
      f[4:1] = cmds[$urandom_range(0, 4)];
    return {cond, op, f, 20'($urandom)};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (PCWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0)
      $display("FAIL reset: write strobes not forced low (PCW=%b IRW=%b RW=%b MW=%b)",
               PCWrite, IRWrite, RegWrite, MemWrite);
    else
      passes++;
    sb.push_back(mkrec(16'h0000, 16'hF000, 4'd10));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (IRWrite !== 1'b1 || PCWrite !== 1'b1)
      $display("FAIL first fetch after reset: IRWrite=%b PCWrite=%b", IRWrite, PCWrite);
    else
      passes++;

    run_instr(32'hE0802001, -1, 5'h00);
    run_instr(32'hE5903004, -1, 5'h00);
    run_instr(32'hE1500000, -1, 5'h14);
    run_instr(32'h10811002, -1, 5'h00);
    run_instr(32'hEA000002, -1, 5'h00);
    run_instr(32'hE1500000, -1, 5'h10);
    run_instr(32'h0A000002, -1, 5'h00);
    run_instr(32'h05800000, -1, 5'h00);
    run_instr(32'hEC000000, -1, 5'h00);
    run_instr(32'hE1500000, -1, 5'h1F);
    run_instr(32'hE5903004,  3, 5'h00);
    run_instr(32'h0A000002, -1, 5'h00);
    run_instr(32'h1A000002, -1, 5'h00);

    for (int unsigned n = 0; n < 250; n++) begin
      if ($urandom_range(0, 11) == 0)
        run_instr(rand_instr(), $urandom_range(0, 4), 5'h00);
      else
        run_instr(rand_instr(), -1, 5'h00);
    end

    @(negedge clk);
    if (checks < 12)
      $display("FAIL too few checks executed: %0d", checks);
    if (passes != checks)
      $display("FAIL %0d of %0d checks failed", checks - passes, checks);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
